// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver.
// The serial pin is brought into the clock domain through a two-flop synchronizer.
// A falling edge is then qualified at the middle of the start bit, and every later bit is
// sampled one bit period after the previous sample point, so each sample lands near a bit centre.
// A good frame produces a one-cycle o_Rx_DV pulse and updates o_Rx_Byte.
// A low stop bit produces a one-cycle o_Rx_Frame_Err pulse. After that the receiver stays in
// WAIT_HIGH until the line returns high, so a held break yields only one error.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 87
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Frame_Err,
  output logic       o_Rx_Active,
  output logic [2:0] o_Rx_State
);

  // State codes are visible on o_Rx_State, so the values are fixed.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_CLEANUP   = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } state_e;

  // Terminal counts. The start bit is checked halfway through; every later bit waits a full period.
  localparam logic [15:0] HALF_LAST = 16'((CLKS_PER_BIT - 1) / 2);
  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);

  // Synchronizer flops. rx_q is the synchronized line that all logic uses.
  logic rx_meta_q;
  logic rx_q;

  // FSM state.
  state_e state_q;
  state_e state_d;

  // Datapath registers and their next-state values.
  logic [15:0] clk_count_q;
  logic [15:0] clk_count_d;
  logic [2:0]  bit_index_q;
  logic [2:0]  bit_index_d;
  logic [7:0]  shift_q;
  logic [7:0]  shift_d;
  logic [7:0]  byte_q;
  logic [7:0]  byte_d;
  logic        dv_q;
  logic        dv_d;
  logic        frame_err_q;
  logic        frame_err_d;
  logic        active_q;
  logic        active_d;

  // Terminal-count flags, shared by the next-state and output processes.
  logic half_hit;
  logic bit_hit;

  assign half_hit = (clk_count_q == HALF_LAST);
  assign bit_hit  = (clk_count_q == BIT_LAST);

  // Two-flop synchronizer. It resets to the idle (high) line level so reset cannot fake a start bit.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      rx_meta_q <= 1'b1;
      rx_q      <= 1'b1;
    end else begin
      rx_meta_q <= i_Rx_Serial;
      rx_q      <= rx_meta_q;
    end
  end

  // State register.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: bit timing comes from the shared cycle counter.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!rx_q) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        // If the line is high again at mid start bit, the low pulse was a glitch.
        if (half_hit) begin
          state_d = rx_q ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_hit && (bit_index_q == 3'd7)) begin
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_hit) begin
          state_d = rx_q ? ST_CLEANUP : ST_WAIT_HIGH;
        end
      end
      ST_CLEANUP: begin
        state_d = ST_IDLE;
      end
      ST_WAIT_HIGH: begin
        // Leave only once the line has recovered, so a held break is not re-read as frames.
        if (rx_q) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output and datapath logic: counters, the shift register and the strobes, decoded per state.
  always_comb begin
    clk_count_d = clk_count_q;
    bit_index_d = bit_index_q;
    shift_d     = shift_q;
    byte_d      = byte_q;
    active_d    = active_q;
    // Strobes default low, which makes them single-cycle pulses.
    dv_d        = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        clk_count_d = 16'd0;
        bit_index_d = 3'd0;
      end
      ST_START: begin
        if (half_hit) begin
          clk_count_d = 16'd0;
          if (!rx_q) begin
            active_d = 1'b1;
          end
        end else begin
          clk_count_d = clk_count_q + 16'd1;
        end
      end
      ST_DATA: begin
        if (bit_hit) begin
          clk_count_d          = 16'd0;
          shift_d[bit_index_q] = rx_q;
          bit_index_d          = (bit_index_q == 3'd7) ? 3'd0 : (bit_index_q + 3'd1);
        end else begin
          clk_count_d = clk_count_q + 16'd1;
        end
      end
      ST_STOP: begin
        if (bit_hit) begin
          clk_count_d = 16'd0;
          active_d    = 1'b0;
          if (rx_q) begin
            byte_d = shift_q;
            dv_d   = 1'b1;
          end else begin
            // A bad frame keeps the previous good byte on o_Rx_Byte.
            frame_err_d = 1'b1;
          end
        end else begin
          clk_count_d = clk_count_q + 16'd1;
        end
      end
      ST_CLEANUP: begin
        clk_count_d = 16'd0;
      end
      ST_WAIT_HIGH: begin
        clk_count_d = 16'd0;
      end
      default: begin
        // Unused codes recover silently: no strobes, counters cleared.
        clk_count_d = 16'd0;
        bit_index_d = 3'd0;
        active_d    = 1'b0;
      end
    endcase
  end

  // Datapath and output registers. A reset clears any frame in progress.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      clk_count_q <= 16'd0;
      bit_index_q <= 3'd0;
      shift_q     <= 8'd0;
      byte_q      <= 8'd0;
      dv_q        <= 1'b0;
      frame_err_q <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      clk_count_q <= clk_count_d;
      bit_index_q <= bit_index_d;
      shift_q     <= shift_d;
      byte_q      <= byte_d;
      dv_q        <= dv_d;
      frame_err_q <= frame_err_d;
      active_q    <= active_d;
    end
  end

  assign o_Rx_DV        = dv_q;
  assign o_Rx_Byte      = byte_q;
  assign o_Rx_Frame_Err = frame_err_q;
  assign o_Rx_Active    = active_q;
  assign o_Rx_State     = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: builds a complete pin/reset waveform, then predicts every output cycle from it.
// The prediction comes from the receiver rules: a low line becomes visible after synchronizer
// and IDLE latency, then the model samples at mid start bit and every bit period after that.
// The waveform is then played into the DUT, and the outputs are compared on every cycle.
// Literal checks pin down the directed scenarios.
module tb_uart_rx;
  localparam int CPB  = 8;
  localparam int HALF = (CPB - 1) / 2;
  localparam int MAXC = 4096;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pin;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic       rx_fe;
  logic       rx_active;
  logic [2:0] rx_state;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock        (clk),
    .i_Rst_n        (rst_n),
    .i_Rx_Serial    (pin),
    .o_Rx_DV        (rx_dv),
    .o_Rx_Byte      (rx_byte),
    .o_Rx_Frame_Err (rx_fe),
    .o_Rx_Active    (rx_active),
    .o_Rx_State     (rx_state)
  );

  always #5 clk = ~clk;

  // Stimulus: index n is the value driven just after clock edge n.
  bit         pin_a   [MAXC];
  bit         rstn_a  [MAXC];
  // Expected outputs just after edge n.
  bit         exp_dv  [MAXC];
  bit         exp_fe  [MAXC];
  bit         exp_act [MAXC];
  bit [2:0]   exp_st  [MAXC];
  bit [7:0]   exp_byte[MAXC];
  bit         dv_ev   [MAXC];
  bit [7:0]   dv_byte [MAXC];
  logic [13:0] act_vec[MAXC];

  int len = 0;
  int n_tests = 0;
  int n_fail = 0;
  int jit_cum = 0;
  int t1_fall, g0, g1, hold_mid, rst_at;
  int dv_cycles[$];
  logic [7:0] got_bytes[$];
  int fe_count = 0;
  int both_count = 0;

  task automatic put(input bit v, input int cnt);
    for (int k = 0; k < cnt; k++) begin
      if (len < MAXC) begin
        pin_a[len]  = v;
        rstn_a[len] = 1'b1;
        len++;
      end
    end
  endtask

  // Bit width with optional +/-1 jitter. Drift is kept within one clock so samples stay inside bits.
  function automatic int bit_width(input bit jitter);
    int d;
    if (!jitter) return CPB;
    d = int'($urandom_range(2, 0)) - 1;
    if (jit_cum + d > 1 || jit_cum + d < -1) d = -d;
    jit_cum += d;
    return CPB + d;
  endfunction

  task automatic send_frame(input logic [7:0] b, input bit stop_v, input int stop_w, input bit jitter);
    jit_cum = 0;
    put(1'b0, bit_width(jitter));
    for (int i = 0; i < 8; i++) put(b[i], bit_width(jitter));
    put(stop_v, stop_w);
  endtask

  // True if the DUT is held in reset at edge e.
  function automatic bit rst_edge(input int e);
    if (e < 1) return 1'b1;
    if (e > len) return 1'b0;
    return !rstn_a[e - 1];
  endfunction

  // Line level that the control logic sees at edge e: the pin three drives earlier, or high when the synchronizer was in reset.
  function automatic bit pin_seen(input int e);
    if (e < 3) return 1'b1;
    if (rst_edge(e - 1) || rst_edge(e - 2)) return 1'b1;
    if (e - 3 >= len) return 1'b1;
    return pin_a[e - 3];
  endfunction

  // Frame-level reference: find each start, place the sample points arithmetically, and fill the expected outputs.
  task automatic build_model();
    int e, d, c, s, w, lim, nx;
    logic [7:0] b;
    logic [7:0] cur;
    e = 1;
    while (e < len) begin
      if (rst_edge(e) || pin_seen(e)) begin
        e++;
        continue;
      end
      d = e;
      lim = d + 1;
      while (lim < len && !rst_edge(lim)) lim++;
      c = d + HALF + 1;
      for (int n = d; n < c && n < lim; n++) exp_st[n] = 3'd1;
      if (c >= lim) begin
        e = lim;
        continue;
      end
      if (pin_seen(c)) begin
        e = c + 1;
        continue;
      end
      for (int i = 0; i < 8; i++) b[i] = pin_seen(c + CPB * (i + 1));
      s = c + 9 * CPB;
      for (int n = c; n < s && n < lim; n++) begin
        exp_st[n]  = (n < c + 8 * CPB) ? 3'd2 : 3'd3;
        exp_act[n] = 1'b1;
      end
      if (s >= lim) begin
        e = lim;
        continue;
      end
      if (pin_seen(s)) begin
        exp_st[s]  = 3'd4;
        exp_dv[s]  = 1'b1;
        dv_ev[s]   = 1'b1;
        dv_byte[s] = b;
        nx = s + 2;
      end else begin
        exp_fe[s] = 1'b1;
        w = s + 1;
        while (w < lim && !pin_seen(w)) w++;
        for (int n = s; n < w; n++) exp_st[n] = 3'd5;
        nx = w + 1;
      end
      e = (nx < lim) ? nx : lim;
    end
    cur = 8'h00;
    for (int n = 1; n < len; n++) begin
      if (rst_edge(n)) cur = 8'h00;
      if (dv_ev[n]) cur = dv_byte[n];
      exp_byte[n] = cur;
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  initial begin
    int nglitch;
    logic [7:0] rb;
    // Power-up reset with the line idle.
    for (int k = 0; k < 4; k++) begin
      pin_a[len] = 1'b1;
      rstn_a[len] = 1'b0;
      len++;
    end
    put(1'b1, 10);
    // Two back-to-back frames with exactly one stop bit.
    t1_fall = len;
    send_frame(8'hA5, 1'b1, CPB, 1'b0);
    send_frame(8'h3C, 1'b1, CPB, 1'b0);
    put(1'b1, 20);
    // A 3-clock glitch.
    g0 = len;
    put(1'b0, 3);
    put(1'b1, 30);
    g1 = len;
    // 0x55 with a low stop bit, followed by a held break.
    send_frame(8'h55, 1'b0, CPB + 40, 1'b0);
    hold_mid = len - 10;
    put(1'b1, 12);
    send_frame(8'h81, 1'b1, CPB, 1'b0);
    put(1'b1, 20);
    // Reset pulse during bit 4 of 0xFF.
    put(1'b0, CPB);
    put(1'b1, 4 * CPB + 3);
    rst_at = len;
    for (int k = 0; k < 2; k++) begin
      pin_a[len] = 1'b1;
      rstn_a[len] = 1'b0;
      len++;
    end
    put(1'b1, 40);
    send_frame(8'h00, 1'b1, CPB, 1'b0);
    put(1'b1, 20);
    // Jittered 0x96.
    send_frame(8'h96, 1'b1, CPB, 1'b1);
    put(1'b1, 20);
    // Random traffic with occasional short glitches and variable stop/idle times.
    for (int k = 0; k < 24; k++) begin
      if ($urandom_range(4, 0) == 0) begin
        nglitch = int'($urandom_range(3, 1));
        put(1'b0, nglitch);
        put(1'b1, 12);
      end
      rb = 8'($urandom_range(255, 0));
      send_frame(rb, 1'b1, CPB + int'($urandom_range(4, 0)), $urandom_range(1, 0) == 1);
    end
    put(1'b1, 30);

    build_model();

    // Playback and per-cycle comparison against the model.
    pin   = pin_a[0];
    rst_n = rstn_a[0];
    for (int n = 1; n < len; n++) begin
      @(posedge clk);
      #1;
      act_vec[n] = {rx_dv, rx_fe, rx_active, rx_state, rx_byte};
      if (rx_dv) begin
        dv_cycles.push_back(n);
        got_bytes.push_back(rx_byte);
      end
      if (rx_fe) fe_count++;
      if (rx_dv && rx_fe) both_count++;
      n_tests++;
      if (act_vec[n] !== {exp_dv[n], exp_fe[n], exp_act[n], exp_st[n], exp_byte[n]}) begin
        n_fail++;
        $display("FAIL cycle %0d outputs: got dv=%b fe=%b act=%b st=%0d byte=%h, want dv=%b fe=%b act=%b st=%0d byte=%h",
                 n, rx_dv, rx_fe, rx_active, rx_state, rx_byte,
                 exp_dv[n], exp_fe[n], exp_act[n], exp_st[n], exp_byte[n]);
      end
      pin   = pin_a[n];
      rst_n = rstn_a[n];
    end

    // Literal expectations.
    check("reset_outputs", 32'(act_vec[2]), 32'h0);
    check("dv_count_min", 32'(dv_cycles.size() >= 5), 32'h1);
    if (dv_cycles.size() >= 5) begin
      check("byte0_A5", 32'(got_bytes[0]), 32'hA5);
      check("byte1_3C", 32'(got_bytes[1]), 32'h3C);
      check("byte2_81", 32'(got_bytes[2]), 32'h81);
      check("byte3_00", 32'(got_bytes[3]), 32'h00);
      check("byte4_96", 32'(got_bytes[4]), 32'h96);
      check("dv_latency_in_76_80",
            32'((dv_cycles[0] - t1_fall >= 76) && (dv_cycles[0] - t1_fall <= 80)), 32'h1);
    end
    check("frame_err_count", 32'(fe_count), 32'd1);
    check("dv_fe_overlap", 32'(both_count), 32'd0);
    begin
      bit saw_start;
      bit bad;
      saw_start = 1'b0;
      bad = 1'b0;
      for (int n = g0 + 1; n < g1; n++) begin
        if (act_vec[n][10:8] == 3'd1) saw_start = 1'b1;
        if (act_vec[n][13] || act_vec[n][11]) bad = 1'b1;
      end
      check("glitch_saw_start", 32'(saw_start), 32'h1);
      check("glitch_no_dv_no_active", 32'(bad), 32'h0);
      check("glitch_back_idle", 32'(act_vec[g1 - 1][10:8]), 32'd0);
    end
    check("break_wait_high_state", 32'(act_vec[hold_mid][10:8]), 32'd5);
    check("break_byte_unchanged", 32'(act_vec[hold_mid][7:0]), 32'h3C);
    check("active_before_reset", 32'(act_vec[rst_at][11]), 32'h1);
    check("outputs_in_reset", 32'(act_vec[rst_at + 1]), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
